// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, widths, state encoding and opcode-class helpers for the ALU sequencer
package alu_pkg;

    localparam int BITS      = 32;
    localparam int SIG_COUNT = 13;
    localparam int OP_BITS   = 4;

    localparam logic [OP_BITS-1:0] OP_ADD   = 4'd0;
    localparam logic [OP_BITS-1:0] OP_SUB   = 4'd1;
    localparam logic [OP_BITS-1:0] OP_MUL   = 4'd2;
    localparam logic [OP_BITS-1:0] OP_DIV   = 4'd3;
    localparam logic [OP_BITS-1:0] OP_SHR   = 4'd4;
    localparam logic [OP_BITS-1:0] OP_SHL   = 4'd5;
    localparam logic [OP_BITS-1:0] OP_ROR   = 4'd6;
    localparam logic [OP_BITS-1:0] OP_ROL   = 4'd7;
    localparam logic [OP_BITS-1:0] OP_AND   = 4'd8;
    localparam logic [OP_BITS-1:0] OP_OR    = 4'd9;
    localparam logic [OP_BITS-1:0] OP_NEG   = 4'd10;
    localparam logic [OP_BITS-1:0] OP_NOT   = 4'd11;
    localparam logic [OP_BITS-1:0] OP_INCPC = 4'd12;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_GET_B  = 3'd1,
        ST_EXEC   = 3'd2,
        ST_OUT_LO = 3'd3,
        ST_OUT_HI = 3'd4,
        ST_ERR    = 3'd5
    } state_t;

    // Ops whose 64-bit result carries meaning in both halves of Z.
    function automatic logic op_is_wide(input logic [OP_BITS-1:0] op);
        return (op == OP_MUL) || (op == OP_DIV);
    endfunction

    // Ops that take a single operand and skip the second-operand fetch.
    function automatic logic op_is_unary(input logic [OP_BITS-1:0] op);
        return (op == OP_NEG) || (op == OP_NOT) || (op == OP_INCPC);
    endfunction

endpackage

// File: rtl/alu_op_decoder.sv
// rtl/alu_op_decoder.sv - combinational opcode classifier and one-hot ALU control generator
//  op_code   in   OP_BITS    binary opcode
//  onehot    out  SIG_COUNT  1<<op_code for legal opcodes, zero for illegal ones
//  is_unary  out  1          neg/not/incPC
//  is_y_only out  1          incPC: the single operand goes to Y, X is zeroed
//  is_wide   out  1          mul/div: result returned as two beats
//  illegal   out  1          opcode 13-15
module alu_op_decoder
    import alu_pkg::*;
(
    input  logic [OP_BITS-1:0]   op_code,
    output logic [SIG_COUNT-1:0] onehot,
    output logic                 is_unary,
    output logic                 is_y_only,
    output logic                 is_wide,
    output logic                 illegal
);

    always_comb begin
        illegal   = (op_code > OP_INCPC);
        onehot    = illegal ? '0 : (SIG_COUNT'(1) << op_code);
        is_unary  = op_is_unary(op_code);
        is_y_only = (op_code == OP_INCPC);
        is_wide   = op_is_wide(op_code);
    end

endmodule

// File: rtl/alu_op_sequencer.sv
// rtl/alu_op_sequencer.sv - host-side sequencer: opcode/operand handshakes, one EXEC cycle, result beats from Z
//  clk, clr                    clock, synchronous active-low reset
//  op_valid/op_ready/op_code   opcode + first operand (bus_in) handshake, accepted in IDLE only
//  opnd_valid/opnd_ready       second operand (bus_in) handshake, accepted in GET_B only
//  alu_ctrl/alu_x/alu_y        one-hot control and registered operands to the ALU
//  alu_result                  ALU 64-bit result, captured into Z at the end of EXEC
//  res_valid/res_ready         result beat handshake; res_data/res_hi/res_err describe the beat
//  busy                        high whenever the sequencer is not idle
module alu_op_sequencer #(
    parameter int BITS      = 32,
    parameter int SIG_COUNT = 13,
    parameter int OP_BITS   = 4
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 op_valid,
    output logic                 op_ready,
    input  logic [OP_BITS-1:0]   op_code,
    input  logic                 opnd_valid,
    output logic                 opnd_ready,
    input  logic [BITS-1:0]      bus_in,
    output logic [SIG_COUNT-1:0] alu_ctrl,
    output logic [BITS-1:0]      alu_x,
    output logic [BITS-1:0]      alu_y,
    input  logic [2*BITS-1:0]    alu_result,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [BITS-1:0]      res_data,
    output logic                 res_hi,
    output logic                 res_err,
    output logic                 busy
);
    import alu_pkg::*;

    state_t              state_q, state_d;
    logic [OP_BITS-1:0]  op_q, op_d;
    logic [BITS-1:0]     alu_x_q, alu_x_d;
    logic [BITS-1:0]     alu_y_q, alu_y_d;
    logic [2*BITS-1:0]   z_q, z_d;

    // One decoder serves both phases: in IDLE it classifies the incoming
    // opcode for routing, afterwards it decodes the latched op_q.
    logic [OP_BITS-1:0]   dec_op;
    logic [SIG_COUNT-1:0] dec_onehot;
    logic                 dec_unary, dec_y_only, dec_wide, dec_illegal;

    assign dec_op = (state_q == ST_IDLE) ? op_code : op_q;

    alu_op_decoder u_decoder (
        .op_code   (dec_op),
        .onehot    (dec_onehot),
        .is_unary  (dec_unary),
        .is_y_only (dec_y_only),
        .is_wide   (dec_wide),
        .illegal   (dec_illegal)
    );

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        alu_x_d = alu_x_q;
        alu_y_d = alu_y_q;
        z_d     = z_q;

        unique case (state_q)
            ST_IDLE: begin
                if (op_valid) begin
                    op_d = op_code;
                    if (dec_illegal) begin
                        state_d = ST_ERR;
                    end else if (dec_y_only) begin
                        alu_x_d = '0;
                        alu_y_d = bus_in;
                        state_d = ST_EXEC;
                    end else if (dec_unary) begin
                        alu_x_d = bus_in;
                        alu_y_d = '0;
                        state_d = ST_EXEC;
                    end else begin
                        alu_x_d = bus_in;
                        state_d = ST_GET_B;
                    end
                end
            end
            ST_GET_B: begin
                if (opnd_valid) begin
                    alu_y_d = bus_in;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                z_d     = alu_result;
                state_d = ST_OUT_LO;
            end
            ST_OUT_LO: begin
                if (res_ready) begin
                    state_d = dec_wide ? ST_OUT_HI : ST_IDLE;
                end
            end
            ST_OUT_HI, ST_ERR: begin
                if (res_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Every output depends only on registered state, never on a live input.
    always_comb begin
        op_ready   = (state_q == ST_IDLE);
        opnd_ready = (state_q == ST_GET_B);
        busy       = (state_q != ST_IDLE);
        alu_ctrl   = (state_q == ST_EXEC) ? dec_onehot : '0;
        alu_x      = alu_x_q;
        alu_y      = alu_y_q;
        res_valid  = (state_q == ST_OUT_LO) || (state_q == ST_OUT_HI) || (state_q == ST_ERR);
        res_hi     = (state_q == ST_OUT_HI);
        res_err    = (state_q == ST_ERR);
        res_data   = '0;
        if (state_q == ST_OUT_LO) begin
            res_data = z_q[BITS-1:0];
        end else if (state_q == ST_OUT_HI) begin
            res_data = z_q[2*BITS-1:BITS];
        end
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state_q <= ST_IDLE;
            op_q    <= '0;
            alu_x_q <= '0;
            alu_y_q <= '0;
            z_q     <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            alu_x_q <= alu_x_d;
            alu_y_q <= alu_y_d;
            z_q     <= z_d;
        end
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb/tb_alu_op_sequencer.sv - self-checking bench for alu_op_sequencer with a behavioural ALU
module tb_alu_op_sequencer;

    logic        clk = 1'b0;
    logic        clr;
    logic        op_valid;
    logic        op_ready;
    logic [3:0]  op_code;
    logic        opnd_valid;
    logic        opnd_ready;
    logic [31:0] bus_in;
    logic [12:0] alu_ctrl;
    logic [31:0] alu_x;
    logic [31:0] alu_y;
    logic [63:0] alu_result;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_hi;
    logic        res_err;
    logic        busy;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    alu_op_sequencer #(.BITS(32), .SIG_COUNT(13), .OP_BITS(4)) dut (
        .clk        (clk),
        .clr        (clr),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_code    (op_code),
        .opnd_valid (opnd_valid),
        .opnd_ready (opnd_ready),
        .bus_in     (bus_in),
        .alu_ctrl   (alu_ctrl),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_result (alu_result),
        .res_valid  (res_valid),
        .res_ready  (res_ready),
        .res_data   (res_data),
        .res_hi     (res_hi),
        .res_err    (res_err),
        .busy       (busy)
    );

    // Combinational ALU standing in for the real one, driven by the one-hot control.
    logic signed [63:0] sx64, sy64;
    logic signed [31:0] quo, rem;
    assign sx64 = {{32{alu_x[31]}}, alu_x};
    assign sy64 = {{32{alu_y[31]}}, alu_y};
    always_comb begin
        quo = '0;
        rem = '0;
        if (alu_y != 32'd0) begin
            quo = $signed(alu_x) / $signed(alu_y);
            rem = $signed(alu_x) % $signed(alu_y);
        end
    end
    always_comb begin
        alu_result = '0;
        if (alu_ctrl[0])  alu_result = {32'd0, alu_x + alu_y};
        if (alu_ctrl[1])  alu_result = {32'd0, alu_x - alu_y};
        if (alu_ctrl[2])  alu_result = sx64 * sy64;
        if (alu_ctrl[3])  alu_result = {rem, quo};
        if (alu_ctrl[4])  alu_result = {32'd0, alu_x >> alu_y[4:0]};
        if (alu_ctrl[5])  alu_result = {32'd0, alu_x << alu_y[4:0]};
        if (alu_ctrl[6])  alu_result = {32'd0, 32'({alu_x, alu_x} >> alu_y[4:0])};
        if (alu_ctrl[7])  alu_result = {32'd0, 32'(({alu_x, alu_x} << alu_y[4:0]) >> 32)};
        if (alu_ctrl[8])  alu_result = {32'd0, alu_x & alu_y};
        if (alu_ctrl[9])  alu_result = {32'd0, alu_x | alu_y};
        if (alu_ctrl[10]) alu_result = {32'd0, 32'd0 - alu_x};
        if (alu_ctrl[11]) alu_result = {32'd0, ~alu_x};
        if (alu_ctrl[12]) alu_result = {32'd0, alu_y + 32'd4};
    end

    // Reference: what the operation means, in terms of the operands as handed over.
    function automatic logic [63:0] ref_z(input int op, input logic [31:0] a, input logic [31:0] b);
        int     sa, sb, s;
        longint p;
        sa = a;
        sb = b;
        s  = int'(b & 32'd31);
        case (op)
            0:  return {32'd0, a + b};
            1:  return {32'd0, a - b};
            2:  begin p = longint'(sa) * longint'(sb); return p; end
            3:  return {32'(sa % sb), 32'(sa / sb)};
            4:  return {32'd0, a >> s};
            5:  return {32'd0, a << s};
            6:  return {32'd0, (a >> s) | (a << (32 - s))};
            7:  return {32'd0, (a << s) | (a >> (32 - s))};
            8:  return {32'd0, a & b};
            9:  return {32'd0, a | b};
            10: return {32'd0, -a};
            11: return {32'd0, ~a};
            12: return {32'd0, a + 32'd4};
            default: return 64'd0;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Present one result beat, optionally stall the consumer (poking op_valid
    // meanwhile, which must be ignored), then take it.
    task automatic take_beat(input string tag, input logic [31:0] data, input logic hi,
                             input logic err, input int stall);
        chk({tag, "_valid"}, res_valid, 1'b1);
        chk({tag, "_data"},  res_data, data);
        chk({tag, "_hi"},    res_hi, hi);
        chk({tag, "_err"},   res_err, err);
        for (int i = 0; i < stall; i++) begin
            op_valid = 1'b1;
            op_code  = 4'($urandom_range(0, 15));
            bus_in   = $urandom;
            tick();
            chk({tag, "_stall_valid"}, res_valid, 1'b1);
            chk({tag, "_stall_data"},  res_data, data);
            chk({tag, "_stall_hi"},    res_hi, hi);
            chk({tag, "_stall_ctrl"},  alu_ctrl, 13'd0);
            chk({tag, "_stall_opry"},  op_ready, 1'b0);
        end
        op_valid  = 1'b0;
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
    endtask

    task automatic run_op(input int op, input logic [31:0] a, input logic [31:0] b, input int stall);
        logic [63:0] z;
        logic [12:0] oh;
        bit          legal, unary, wide;
        legal = (op <= 12);
        unary = (op >= 10) && (op <= 12);
        wide  = (op == 2) || (op == 3);
        z     = ref_z(op, a, b);
        oh    = 13'd1 << op;

        chk("idle_op_ready", op_ready, 1'b1);
        op_valid = 1'b1;
        op_code  = 4'(op);
        bus_in   = a;
        tick();
        op_valid = 1'b0;
        bus_in   = $urandom;

        if (!legal) begin
            chk("err_ctrl", alu_ctrl, 13'd0);
            take_beat("err", 32'd0, 1'b0, 1'b1, stall);
        end else begin
            if (!unary) begin
                chk("getb_opnd_ready", opnd_ready, 1'b1);
                chk("getb_res_valid", res_valid, 1'b0);
                for (int g = $urandom_range(0, 2); g > 0; g--) begin
                    tick();
                    chk("getb_wait", opnd_ready, 1'b1);
                end
                opnd_valid = 1'b1;
                bus_in     = b;
                tick();
                opnd_valid = 1'b0;
                bus_in     = $urandom;
            end
            chk("exec_ctrl", alu_ctrl, oh);
            chk("exec_opnd_ready", opnd_ready, 1'b0);
            chk("exec_res_valid", res_valid, 1'b0);
            chk("exec_x", alu_x, (op == 12) ? 32'd0 : a);
            chk("exec_y", alu_y, (op == 12) ? a : ((op >= 10) ? 32'd0 : b));
            tick();
            take_beat("lo", z[31:0], 1'b0, 1'b0, stall);
            if (wide) take_beat("hi", z[63:32], 1'b1, 1'b0, 0);
        end
        chk("done_busy", busy, 1'b0);
        chk("done_res_valid", res_valid, 1'b0);
    endtask

    task automatic pulse_reset();
        clr = 1'b0;
        tick();
        clr = 1'b1;
        chk("rst_op_ready", op_ready, 1'b1);
        chk("rst_res_valid", res_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_opnd_ready", opnd_ready, 1'b0);
        chk("rst_res_hi", res_hi, 1'b0);
        chk("rst_alu_x", alu_x, 32'd0);
        tick();
        chk("rst_no_beat", res_valid, 1'b0);
    endtask

    initial begin
        clr        = 1'b0;
        op_valid   = 1'b0;
        op_code    = '0;
        opnd_valid = 1'b0;
        bus_in     = '0;
        res_ready  = 1'b0;
        tick();
        tick();
        chk("reset_op_ready", op_ready, 1'b1);
        chk("reset_res_valid", res_valid, 1'b0);
        chk("reset_res_err", res_err, 1'b0);
        chk("reset_res_hi", res_hi, 1'b0);
        chk("reset_ctrl", alu_ctrl, 13'd0);
        chk("reset_x", alu_x, 32'd0);
        chk("reset_y", alu_y, 32'd0);
        chk("reset_busy", busy, 1'b0);
        clr = 1'b1;
        tick();

        run_op(0, 32'd5, 32'd7, 0);
        run_op(2, 32'hFFFF_FFFD, 32'd4, 3);
        run_op(11, 32'h0000_FFFF, 32'd0, 0);
        run_op(12, 32'd8, 32'd0, 0);
        run_op(14, 32'h1234_5678, 32'd0, 1);

        // Abort during GET_B.
        op_valid = 1'b1;
        op_code  = 4'd2;
        bus_in   = 32'd9;
        tick();
        op_valid = 1'b0;
        chk("abort_getb_opnd_ready", opnd_ready, 1'b1);
        pulse_reset();

        // Abort during OUT_LO, before the HI beat.
        op_valid = 1'b1;
        op_code  = 4'd2;
        bus_in   = 32'hFFFF_FFFD;
        tick();
        op_valid   = 1'b0;
        opnd_valid = 1'b1;
        bus_in     = 32'd4;
        tick();
        opnd_valid = 1'b0;
        tick();
        chk("abort_lo_valid", res_valid, 1'b1);
        chk("abort_lo_data", res_data, 32'hFFFF_FFF4);
        pulse_reset();
        run_op(0, 32'd5, 32'd7, 0);

        for (int i = 0; i < 60; i++) begin
            int          op;
            logic [31:0] a, b;
            op = $urandom_range(0, 15);
            a  = $urandom;
            b  = (op == 3) ? 32'($urandom_range(1, 1000)) : $urandom;
            run_op(op, a, b, $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
